// File: rtl/cpu_mc.sv
// Multi-cycle core: FETCH -> EXEC -> (MEM) -> FETCH, with ready/valid fetch and data ports.
// HALT is terminal until reset; r0 is hardwired to zero by never accepting writes.
module cpu_mc #(
   parameter int                    WORD_WIDTH  = 16,
   parameter int                    NUM_REGS    = 8,
   parameter logic [WORD_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [WORD_WIDTH-1:0] STACK_BEGIN = WORD_WIDTH'(16'hF7FF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic                  instr_req,
   output logic [WORD_WIDTH-1:0] instr_addr,
   input  logic                  instr_ready,
   input  logic [WORD_WIDTH-1:0] instr,
   output logic                  data_req,
   output logic                  data_we,
   output logic [WORD_WIDTH-1:0] data_addr,
   output logic [WORD_WIDTH-1:0] data_out,
   input  logic                  data_ready,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [WORD_WIDTH-1:0] pc,
   output logic                  halted,
   output logic                  retire
);
   localparam int W  = WORD_WIDTH;
   localparam int RW = $clog2(NUM_REGS);
   localparam int IW = W - 4 - 2 * RW;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_BEQ  = 4'h5;
   localparam logic [3:0] OP_LW   = 4'h6;
   localparam logic [3:0] OP_SW   = 4'h7;
   localparam logic [3:0] OP_J    = 4'h8;
   localparam logic [3:0] OP_JL   = 4'h9;
   localparam logic [3:0] OP_RTS  = 4'hA;
   localparam logic [3:0] OP_PUSH = 4'hB;
   localparam logic [3:0] OP_POP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t         state;
   logic [W-1:0]   ir;
   logic [W-1:0]   pc_q;
   logic [W-1:0]   sp;
   logic [W-1:0]   lr;
   logic [W-1:0]   gpr [NUM_REGS];
   logic [W-1:0]   maddr;
   logic [W-1:0]   mwdata;
   logic           mwe;

   logic [3:0]     op;
   logic [RW-1:0]  rs, rt, rd;
   logic [W-1:0]   simm, jimm;
   logic [W-1:0]   va, vb, vd;
   logic [W-1:0]   pc_inc;
   logic           is_mem, is_store, is_load;

   assign op   = ir[W-1 -: 4];
   assign rs   = ir[3*RW-1 -: RW];
   assign rt   = ir[2*RW-1 -: RW];
   assign rd   = ir[RW-1:0];
   assign simm = {{(W-IW){ir[W-5]}}, ir[W-5:2*RW]};
   assign jimm = {{4{ir[W-5]}}, ir[W-5:0]};

   assign va     = gpr[rs];
   assign vb     = gpr[rt];
   assign vd     = gpr[rd];
   assign pc_inc = pc_q + W'(1);

   assign is_store = (op == OP_SW) || (op == OP_PUSH);
   assign is_load  = (op == OP_LW) || (op == OP_POP);
   assign is_mem   = is_store || is_load;

   logic [W-1:0] wb_val;
   logic         wb_en;
   logic [W-1:0] pc_nxt;
   logic         lr_wr;
   logic [W-1:0] ea;

   always_comb begin
      wb_val = '0;
      wb_en  = 1'b0;
      pc_nxt = pc_inc;
      lr_wr  = 1'b0;
      ea     = simm + vb;
      case (op)
         OP_ADD:  begin wb_en = 1'b1; wb_val = va + vb; end
         OP_SUB:  begin wb_en = 1'b1; wb_val = va - vb; end
         OP_AND:  begin wb_en = 1'b1; wb_val = va & vb; end
         OP_OR:   begin wb_en = 1'b1; wb_val = va | vb; end
         OP_ADDI: begin wb_en = 1'b1; wb_val = simm + vb; end
         OP_BEQ:  if (vb == vd) pc_nxt = pc_inc + simm;
         OP_J:    pc_nxt = jimm;
         OP_JL:   begin pc_nxt = jimm; lr_wr = 1'b1; end
         OP_RTS:  pc_nxt = lr;
         OP_PUSH: ea = sp;
         OP_POP:  ea = sp + W'(1);
         default: ;
      endcase
   end

   // The access is captured on entry to MEM so the bus stays stable across wait states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_FETCH;
         ir     <= '0;
         pc_q   <= RESET_PC;
         sp     <= STACK_BEGIN;
         lr     <= '0;
         maddr  <= '0;
         mwdata <= '0;
         mwe    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (instr_ready) begin
                  ir    <= instr;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (en) begin
                  if (is_mem) begin
                     maddr  <= ea;
                     mwdata <= vd;
                     mwe    <= is_store;
                     state  <= S_MEM;
                  end else if (op == OP_HALT) begin
                     state <= S_HALT;
                  end else begin
                     if (wb_en && rd != '0) gpr[rd] <= wb_val;
                     if (lr_wr) lr <= pc_inc;
                     pc_q  <= pc_nxt;
                     state <= S_FETCH;
                  end
               end
            end
            S_MEM: begin
               if (data_ready) begin
                  if (is_load && rd != '0) gpr[rd] <= data_in;
                  if (op == OP_PUSH) sp <= sp - W'(1);
                  if (op == OP_POP)  sp <= sp + W'(1);
                  pc_q  <= pc_inc;
                  state <= S_FETCH;
               end
            end
            default: state <= S_HALT;
         endcase
      end
   end

   assign instr_req  = (state == S_FETCH);
   assign instr_addr = pc_q;
   assign data_req   = (state == S_MEM);
   assign data_we    = (state == S_MEM) && mwe;
   assign data_addr  = maddr;
   assign data_out   = mwdata;
   assign pc         = pc_q;
   assign halted     = (state == S_HALT);
   assign retire     = ((state == S_EXEC) && en && !is_mem && (op != OP_HALT)) ||
                       ((state == S_MEM) && data_ready);
endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: ISA-level model predicts each fetched instruction's bus accesses and
// next pc; a monitor pops those predictions as the core presents accesses and retire pulses.
module tb_cpu_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b1, en = 1'b0, instr_ready = 1'b0, data_ready = 1'b0;
   logic [15:0] instr = '0, data_in = '0;
   logic        instr_req, data_req, data_we, halted, retire;
   logic [15:0] instr_addr, data_addr, data_out, pc;

   logic        rst32 = 1'b1, en32 = 1'b1, instr_ready32 = 1'b1, data_ready32 = 1'b0;
   logic [31:0] instr32 = '0, data_in32 = '0;
   logic        instr_req32, data_req32, data_we32, halted32, retire32;
   logic [31:0] instr_addr32, data_addr32, data_out32, pc32;

   always #5 clk = ~clk;

   cpu_mc #(.WORD_WIDTH(16), .NUM_REGS(8)) dut (
      .clk(clk), .rst(rst), .en(en),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_ready(instr_ready), .instr(instr),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_out(data_out),
      .data_ready(data_ready), .data_in(data_in),
      .pc(pc), .halted(halted), .retire(retire));

   cpu_mc #(.WORD_WIDTH(32), .NUM_REGS(16)) dut32 (
      .clk(clk), .rst(rst32), .en(en32),
      .instr_req(instr_req32), .instr_addr(instr_addr32), .instr_ready(instr_ready32), .instr(instr32),
      .data_req(data_req32), .data_we(data_we32), .data_addr(data_addr32), .data_out(data_out32),
      .data_ready(data_ready32), .data_in(data_in32),
      .pc(pc32), .halted(halted32), .retire(retire32));

   int n_cmp = 0, n_err = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic fail(string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event count off (got none/extra, required exactly as predicted)", name);
   endtask

   // ---------------- reference model (ISA level) ----------------
   typedef struct {logic we; logic [15:0] addr; logic [15:0] wd;} acc_t;
   acc_t        q_mem[$];
   logic [15:0] q_pc[$];
   logic [15:0] q_dir[$];
   logic [15:0] m_r [8];
   logic [15:0] m_pc, m_sp, m_lr;
   bit          m_halt;
   logic [15:0] m_mem [logic [15:0]];
   logic [15:0] e_mem [logic [15:0]];

   function automatic logic [15:0] dflt(logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction
   function automatic logic [15:0] mrd(logic [15:0] a);
      return m_mem.exists(a) ? m_mem[a] : dflt(a);
   endfunction
   function automatic logic [15:0] erd(logic [15:0] a);
      return e_mem.exists(a) ? e_mem[a] : dflt(a);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_pc = '0; m_sp = 16'hF7FF; m_lr = '0; m_halt = 0;
      m_mem.delete(); e_mem.delete(); q_mem.delete(); q_pc.delete(); q_dir.delete();
   endtask

   task automatic m_wr(int rd, logic [15:0] v);
      if (rd != 0) m_r[rd] = v;
   endtask

   task automatic m_exec(logic [15:0] i);
      int op = int'(i[15:12]);
      int rs = int'(i[8:6]), rt = int'(i[5:3]), rd = int'(i[2:0]);
      int simm = int'(i[11:6]) - (i[11] ? 64 : 0);
      int sj   = int'(i[11:0]) - (i[11] ? 4096 : 0);
      logic [15:0] a = m_r[rs], b = m_r[rt], c = m_r[rd];
      logic [15:0] nxt = m_pc + 16'd1;
      logic [15:0] ad;
      case (op)
         0:  m_wr(rd, a + b);
         1:  m_wr(rd, a - b);
         2:  m_wr(rd, a & b);
         3:  m_wr(rd, a | b);
         4:  m_wr(rd, 16'(simm + int'(b)));
         5:  if (b == c) nxt = 16'(int'(m_pc) + 1 + simm);
         6:  begin ad = 16'(simm + int'(b)); q_mem.push_back('{1'b0, ad, 16'h0}); m_wr(rd, mrd(ad)); end
         7:  begin ad = 16'(simm + int'(b)); q_mem.push_back('{1'b1, ad, c}); m_mem[ad] = c; end
         8:  nxt = 16'(sj);
         9:  begin m_lr = m_pc + 16'd1; nxt = 16'(sj); end
         10: nxt = m_lr;
         11: begin q_mem.push_back('{1'b1, m_sp, c}); m_mem[m_sp] = c; m_sp = m_sp - 16'd1; end
         12: begin ad = m_sp + 16'd1; q_mem.push_back('{1'b0, ad, 16'h0}); m_wr(rd, mrd(ad)); m_sp = ad; end
         15: m_halt = 1;
         default: ;
      endcase
      if (op != 15) begin
         m_pc = nxt;
         q_pc.push_back(nxt);
      end
   endtask

   function automatic logic [15:0] enc_i(int op, int imm, int rt, int rd);
      return {4'(op), 6'(imm), 3'(rt), 3'(rd)};
   endfunction
   function automatic logic [15:0] enc_j(int op, int j);
      return {4'(op), 12'(j)};
   endfunction
   function automatic logic [15:0] rnd_instr();
      return {4'($urandom_range(14)), 12'($urandom)};
   endfunction

   // ---------------- environment ----------------
   int p_iready = 100, p_dready = 100, p_en = 100, dly_fix = -1;
   bit gen_on = 0;
   int cyc = 0, t_fetch = 0, last_lat = 0, last_reqlen = 0, n_ret = 0;
   bit pend = 0;

   initial begin : fetch_side
      logic [15:0] ins;
      forever begin
         @(posedge clk); #1;
         if (rst) begin instr_ready = 1'b0; continue; end
         if (instr_req && (q_dir.size() > 0 || gen_on) && $urandom_range(99) < p_iready) begin
            ins = (q_dir.size() > 0) ? q_dir.pop_front() : rnd_instr();
            check("fetch_addr", instr_addr, m_pc);
            instr = ins;
            instr_ready = 1'b1;
            m_exec(ins);
         end else begin
            instr_ready = !instr_req && ($urandom_range(3) == 0);
            instr = 16'($urandom);
         end
      end
   end

   initial begin : data_side
      int waitc = 0;
      forever begin
         @(posedge clk); #1;
         if (rst || !data_req) begin
            waitc = 0;
            data_ready = !rst && ($urandom_range(3) == 0);
            data_in = 16'($urandom);
            continue;
         end
         if ((dly_fix >= 0) ? (waitc >= dly_fix) : ($urandom_range(99) < p_dready)) begin
            data_ready = 1'b1;
            if (data_we) e_mem[data_addr] = data_out;
            else data_in = erd(data_addr);
            waitc = 0;
         end else begin
            data_ready = 1'b0;
            data_in = 16'($urandom);
            waitc++;
         end
      end
   end

   initial begin : en_side
      forever begin
         @(posedge clk); #1;
         en = ($urandom_range(99) < p_en);
      end
   end

   initial begin : monitor
      logic [15:0] exp_pc, a0;
      logic        we0;
      acc_t        e;
      int          reqlen = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin pend = 0; reqlen = 0; continue; end
         if (pend) begin check("pc_after_retire", pc, exp_pc); pend = 0; end
         if (instr_req && instr_ready) t_fetch = cyc;
         if (data_req) begin
            if (reqlen == 0) begin
               a0 = data_addr; we0 = data_we;
            end else begin
               check("data_addr_stable", data_addr, a0);
               check("data_we_stable", data_we, we0);
            end
            reqlen++;
            if (data_ready) begin
               last_reqlen = reqlen;
               reqlen = 0;
               if (q_mem.size() == 0) fail("mem_access_unexpected");
               else begin
                  e = q_mem.pop_front();
                  check("data_we", data_we, e.we);
                  check("data_addr", data_addr, e.addr);
                  if (e.we) check("data_out", data_out, e.wd);
               end
            end
         end
         if (retire) begin
            n_ret++;
            last_lat = cyc - t_fetch;
            if (q_pc.size() == 0) fail("retire_unexpected");
            else begin exp_pc = q_pc.pop_front(); pend = 1; end
         end
      end
   end

   task automatic drain(string name, int lim);
      int k = 0;
      while ((q_dir.size() > 0 || q_pc.size() > 0 || q_mem.size() > 0) && k < lim) begin
         @(negedge clk); k++;
      end
      if (k >= lim) fail(name);
      repeat (2) @(negedge clk);
   endtask

   // ---------------- 32-bit / 16-register instance ----------------
   typedef struct {logic we; logic [31:0] addr; logic [31:0] wd;} acc32_t;
   acc32_t      q32[$];
   logic [31:0] prog32 [8];
   logic [31:0] mem32 [logic [31:0]];
   int          n_ret32 = 0;

   function automatic logic [31:0] enc32(int op, int imm, int rt, int rd);
      return {4'(op), 20'(imm), 4'(rt), 4'(rd)};
   endfunction

   initial begin : feed32
      forever begin
         @(negedge clk);
         instr32 = prog32[instr_addr32[2:0]];
      end
   end

   initial begin : data32
      int w = 0;
      forever begin
         @(posedge clk); #1;
         if (rst32 || !data_req32) begin data_ready32 = 1'b0; w = 0; end
         else if (w >= 3) begin
            data_ready32 = 1'b1;
            if (data_we32) mem32[data_addr32] = data_out32;
            else data_in32 = mem32.exists(data_addr32) ? mem32[data_addr32] : 32'h0;
            w = 0;
         end else begin data_ready32 = 1'b0; w++; end
      end
   end

   initial begin : mon32
      acc32_t e;
      forever begin
         @(negedge clk);
         if (rst32) continue;
         if (retire32) n_ret32++;
         if (data_req32 && data_ready32) begin
            if (q32.size() == 0) fail("mem32_unexpected");
            else begin
               e = q32.pop_front();
               check("data_we32", data_we32, e.we);
               check("data_addr32", data_addr32, e.addr);
               if (e.we) check("data_out32", data_out32, e.wd);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "timeout");
   end

   // ---------------- directed + random sequence ----------------
   initial begin : main
      int k, r0;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_instr_req", instr_req, 1'b1);
      check("rst_instr_addr", instr_addr, 16'h0);
      check("rst_data_req", data_req, 1'b0);
      check("rst_data_we", data_we, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_retire", retire, 1'b0);
      check("rst_pc", pc, 16'h0);
      rst = 1'b0;

      // ADDI r1,r0,#5 with instant ready
      q_dir.push_back(enc_i(4, 5, 0, 1));
      drain("addi_timeout", 50);
      check("addi_latency", last_lat, 1);
      check("addi_retire_count", n_ret, 1);
      check("addi_pc", pc, 16'h1);

      // LW r2,4(r0) with three wait states, then expose r2 through SW
      e_mem[16'h4] = 16'hBEEF; m_mem[16'h4] = 16'hBEEF;
      dly_fix = 3;
      q_dir.push_back(enc_i(6, 4, 0, 2));
      drain("lw_timeout", 50);
      check("lw_req_cycles", last_reqlen, 4);
      check("lw_latency", last_lat, 5);
      check("lw_retire_count", n_ret, 2);
      dly_fix = -1;
      q_dir.push_back(enc_i(7, 8, 0, 2));
      drain("sw_timeout", 50);
      check("lw_value_stored", erd(16'h8), 16'hBEEF);

      // PUSH r1, POP r3, store r3
      q_dir.push_back(enc_i(11, 0, 0, 1));
      q_dir.push_back(enc_i(12, 0, 0, 3));
      q_dir.push_back(enc_i(7, 9, 0, 3));
      drain("pushpop_timeout", 80);
      check("push_mem", erd(16'hF7FF), 16'h5);
      check("pop_value", erd(16'h9), 16'h5);

      // control flow: BEQ taken/not taken, J wrap, JL/RTS
      q_dir.push_back(enc_j(8, 10));
      q_dir.push_back(enc_i(5, -2, 0, 0));
      q_dir.push_back(enc_j(8, 10));
      q_dir.push_back(enc_i(5, -2, 0, 1));
      q_dir.push_back(enc_j(8, 12'hFFF));
      q_dir.push_back(16'hD000);
      q_dir.push_back(enc_j(8, 12'h020));
      q_dir.push_back(enc_j(9, 12'h030));
      q_dir.push_back(16'hA000);
      drain("flow_timeout", 200);
      check("rts_pc", pc, 16'h21);

      // r0 stays zero
      q_dir.push_back(enc_i(4, 3, 0, 0));
      q_dir.push_back(enc_i(7, 7, 0, 0));
      drain("r0_timeout", 50);
      check("r0_zero", erd(16'h7), 16'h0);

      // en low holds EXEC
      p_en = 0;
      q_dir.push_back(enc_i(4, 1, 0, 4));
      k = 0;
      while (q_dir.size() > 0 && k < 50) begin @(negedge clk); k++; end
      r0 = n_ret;
      repeat (10) @(negedge clk);
      check("en_low_no_retire", n_ret, r0);
      p_en = 100;
      drain("en_timeout", 50);
      check("en_high_retire", n_ret, r0 + 1);

      // random traffic with wait states and en gaps
      p_iready = 60; p_dready = 60; p_en = 80; gen_on = 1;
      repeat (3000) @(negedge clk);
      gen_on = 0; p_iready = 100; p_dready = 100; p_en = 100;
      drain("random_drain", 300);

      // reset in the middle of a stalled store
      p_dready = 0;
      q_dir.push_back(enc_i(7, 3, 0, 1));
      k = 0;
      while (!data_req && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) fail("midmem_no_req");
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("midmem_data_req", data_req, 1'b0);
      check("midmem_data_we", data_we, 1'b0);
      check("midmem_pc", pc, 16'h0);
      check("midmem_instr_req", instr_req, 1'b1);
      m_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      p_dready = 100;

      // HALT freezes the core
      q_dir.push_back(enc_i(4, 7, 0, 5));
      q_dir.push_back(16'hF000);
      k = 0;
      while (!halted && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) fail("halt_timeout");
      r0 = n_ret;
      repeat (20) @(negedge clk);
      check("halt_halted", halted, 1'b1);
      check("halt_instr_req", instr_req, 1'b0);
      check("halt_pc", pc, m_pc);
      check("halt_no_retire", n_ret, r0);
      check("halt_queue_empty", q_pc.size(), 0);

      // 32-bit / 16-register instance
      rst = 1'b1;
      prog32[0] = enc32(4, 5, 0, 1);
      prog32[1] = enc32(6, 4, 0, 2);
      prog32[2] = enc32(7, 8, 0, 2);
      prog32[3] = enc32(11, 0, 0, 1);
      prog32[4] = enc32(12, 0, 0, 3);
      prog32[5] = enc32(7, 9, 0, 3);
      prog32[6] = 32'hF000_0000;
      prog32[7] = 32'hF000_0000;
      mem32[32'h4] = 32'hBEEF;
      q32.push_back('{1'b0, 32'h4, 32'h0});
      q32.push_back('{1'b1, 32'h8, 32'hBEEF});
      q32.push_back('{1'b1, 32'hF7FF, 32'h5});
      q32.push_back('{1'b0, 32'hF7FF, 32'h0});
      q32.push_back('{1'b1, 32'h9, 32'h5});
      repeat (2) @(negedge clk);
      check("rst32_pc", pc32, 32'h0);
      check("rst32_instr_req", instr_req32, 1'b1);
      rst32 = 1'b0;
      k = 0;
      while (!halted32 && k < 300) begin @(negedge clk); k++; end
      if (k >= 300) fail("halt32_timeout");
      check("w32_pc", pc32, 32'h6);
      check("w32_retires", n_ret32, 6);
      check("w32_pending", q32.size(), 0);
      check("w32_pop_value", mem32.exists(32'h9) ? mem32[32'h9] : 32'h0, 32'h5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
